cacc_slcg_en_ctrl: RTL and testbench

Activity-driven enable generator for the CACC second-level clock gate. It runs on the free-running core clock and watches CMAC-side traffic, the CACC internal busy status and CSB register accesses. From these it drives the two SLCG enable sources and the synchronized override strobes that the CACC gate cell consumes. It applies wake latency and idle hysteresis, and returns a wake handshake to upstream so no data arrives before the gated clock is stable.

---
 rtl/cacc_slcg_en_ctrl.sv | 159 +++++++++++++++
 tb/tb_cacc_slcg_en_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacc_slcg_en_ctrl.sv
// Activity-driven enable generator for the CACC second-level clock gate.
// Optional gated-cycle statistics are built only when NVDLA_CACC_SLCG_STATS_EN is defined.
module cacc_slcg_en_ctrl #(
  parameter int unsigned WAKE_LAT  = 2,
  parameter int unsigned IDLE_HOLD = 16,
  parameter int unsigned CSB_HOLD  = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        op_en,
  input  logic        activity_req,
  input  logic        dp_busy,
  input  logic        csb_req,
  input  logic        dla_clk_ovr_on,
  input  logic        global_clk_ovr_on,
  output logic        dla_clk_ovr_on_sync,
  output logic        global_clk_ovr_on_sync,
  output logic        slcg_en_src_0,
  output logic        slcg_en_src_1,
  output logic        wake_ack,
  output logic [1:0]  gate_state,
  input  logic        stats_clr,
  output logic [31:0] gated_cycle_cnt
);

  typedef enum logic [1:0] {
    GATED  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } gate_state_t;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_LAT);
  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_HOLD - 1);
  localparam logic [3:0] CSB_LOAD  = 4'(CSB_HOLD);

  gate_state_t state_q, state_d;
  logic [3:0]  wake_cnt_q, wake_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]  csb_cnt_q;
  logic        dla_meta_q, dla_sync_q;
  logic        glb_meta_q, glb_sync_q;
  logic        en0_r, ack_r;
  logic        trig, ovr;

  assign trig = (op_en & activity_req) | dp_busy;
  assign ovr  = dla_sync_q | glb_sync_q;

  // Two-flop synchronizers for the asynchronous override inputs.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      dla_meta_q <= 1'b0;
      dla_sync_q <= 1'b0;
      glb_meta_q <= 1'b0;
      glb_sync_q <= 1'b0;
    end else begin
      dla_meta_q <= dla_clk_ovr_on;
      dla_sync_q <= dla_meta_q;
      glb_meta_q <= global_clk_ovr_on;
      glb_sync_q <= glb_meta_q;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q    <= GATED;
      wake_cnt_q <= 4'd0;
      idle_cnt_q <= 8'd0;
      en0_r      <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      en0_r      <= (state_d != GATED);
      ack_r      <= (state_d == ACTIVE) || (state_d == DRAIN);
    end
  end

  // The ACTIVE cycle that first sees trig low already counts as idle, so DRAIN
  // leaves one step early and IDLE_HOLD==1 skips DRAIN entirely.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      GATED: begin
        if (trig) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt_q <= 4'd1) begin
          state_d    = ACTIVE;
          wake_cnt_d = 4'd0;
        end else begin
          wake_cnt_d = wake_cnt_q - 4'd1;
        end
      end
      ACTIVE: begin
        if (!trig) begin
          state_d    = (IDLE_HOLD == 1) ? GATED : DRAIN;
          idle_cnt_d = IDLE_LOAD;
        end
      end
      DRAIN: begin
        if (trig) begin
          state_d = ACTIVE;
        end else if (idle_cnt_q <= 8'd1) begin
          state_d    = GATED;
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q - 8'd1;
        end
      end
      default: state_d = GATED;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      csb_cnt_q <= 4'd0;
    end else if (csb_req) begin
      csb_cnt_q <= CSB_LOAD;
    end else if (csb_cnt_q != 4'd0) begin
      csb_cnt_q <= csb_cnt_q - 4'd1;
    end
  end

  assign dla_clk_ovr_on_sync    = dla_sync_q;
  assign global_clk_ovr_on_sync = glb_sync_q;
  assign slcg_en_src_0          = en0_r | ovr;
  assign wake_ack               = ack_r | ovr;
  assign slcg_en_src_1          = csb_req | (csb_cnt_q != 4'd0) | en0_r | ovr;
  assign gate_state             = state_q;

`ifdef NVDLA_CACC_SLCG_STATS_EN
  logic [31:0] gated_cnt_q;

  // Saturating count of cycles with the datapath clock off; clear wins.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      gated_cnt_q <= 32'd0;
    end else if (stats_clr) begin
      gated_cnt_q <= 32'd0;
    end else if (!slcg_en_src_0 && (gated_cnt_q != 32'hFFFF_FFFF)) begin
      gated_cnt_q <= gated_cnt_q + 32'd1;
    end
  end

  assign gated_cycle_cnt = gated_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign gated_cycle_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_cacc_slcg_en_ctrl.sv
// Bench for cacc_slcg_en_ctrl: directed vector table, random traffic against a
// cycle-count reference model, and a gated-cycle statistics sequence.
module tb_cacc_slcg_en_ctrl;

  localparam int WAKE_LAT  = 2;
  localparam int IDLE_HOLD = 16;
  localparam int CSB_HOLD  = 4;

  logic        clk = 1'b0;
  logic        rstn, op_en, activity_req, dp_busy, csb_req;
  logic        dla_ovr, glb_ovr, stats_clr;
  logic        dla_sync, glb_sync, en_src_0, en_src_1, wake_ack;
  logic [1:0]  gate_state;
  logic [31:0] gated_cycle_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: clock-on flag, remaining wake cycles, consecutive idle
  // cycles seen while running, cycles since the last CSB request.
  bit          m_en, m_ack;
  int          m_wake_left, m_idle_run, m_csb_age;
  bit          m_dhist [2];
  bit          m_ghist [2];
  logic [31:0] m_cnt;

  typedef struct {
    bit rstn, op, act, busy, csb, dla, glb, clr;
    int len;
    bit e_en0, e_en1, e_ack, e_dsync, e_gsync;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  cacc_slcg_en_ctrl #(
    .WAKE_LAT (WAKE_LAT),
    .IDLE_HOLD(IDLE_HOLD),
    .CSB_HOLD (CSB_HOLD)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .op_en                 (op_en),
    .activity_req          (activity_req),
    .dp_busy               (dp_busy),
    .csb_req               (csb_req),
    .dla_clk_ovr_on        (dla_ovr),
    .global_clk_ovr_on     (glb_ovr),
    .dla_clk_ovr_on_sync   (dla_sync),
    .global_clk_ovr_on_sync(glb_sync),
    .slcg_en_src_0         (en_src_0),
    .slcg_en_src_1         (en_src_1),
    .wake_ack              (wake_ack),
    .gate_state            (gate_state),
    .stats_clr             (stats_clr),
    .gated_cycle_cnt       (gated_cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit op, bit act, bit busy, bit csb, bit dla,
                              bit glb, bit clr, int len, bit e0, bit e1, bit ea,
                              bit ed, bit eg, logic [1:0] est);
    vec_t v;
    v.rstn = r; v.op = op; v.act = act; v.busy = busy; v.csb = csb;
    v.dla = dla; v.glb = glb; v.clr = clr; v.len = len;
    v.e_en0 = e0; v.e_en1 = e1; v.e_ack = ea; v.e_dsync = ed; v.e_gsync = eg;
    v.e_st = est;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic resetModel();
    m_en = 0; m_ack = 0; m_wake_left = 0; m_idle_run = 0; m_csb_age = 1000;
    m_dhist[0] = 0; m_dhist[1] = 0; m_ghist[0] = 0; m_ghist[1] = 0;
    m_cnt = 32'd0;
  endtask

  task automatic modelStep();
    bit trig, cur_en0;
    cur_en0 = m_en | m_dhist[1] | m_ghist[1];
    if (!rstn) begin
      resetModel();
    end else begin
      trig = (op_en & activity_req) | dp_busy;
      if (!m_en) begin
        if (trig) begin
          m_en = 1;
          m_wake_left = WAKE_LAT;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
        if (m_wake_left == 0) begin
          m_ack = 1;
          m_idle_run = 0;
        end
      end else begin
        if (trig) m_idle_run = 0;
        else m_idle_run++;
        if (m_idle_run >= IDLE_HOLD) begin
          m_en = 0; m_ack = 0; m_idle_run = 0;
        end
      end
      if (stats_clr) m_cnt = 32'd0;
      else if (!cur_en0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      m_dhist[1] = m_dhist[0]; m_dhist[0] = dla_ovr;
      m_ghist[1] = m_ghist[0]; m_ghist[0] = glb_ovr;
      if (csb_req) m_csb_age = 1;
      else if (m_csb_age < 1000) m_csb_age++;
    end
  endtask

  task automatic checkOutput(input vec_t v, input bit use_tbl);
    bit ovr, e_en0, e_en1, e_ack;
    logic [1:0] e_st;
    logic [31:0] e_cnt;
    ovr   = m_dhist[1] | m_ghist[1];
    e_en0 = m_en | ovr;
    e_ack = m_ack | ovr;
    e_en1 = csb_req | (m_csb_age <= CSB_HOLD) | m_en | ovr;
    if (!m_en) e_st = 2'd0;
    else if (!m_ack) e_st = 2'd1;
    else if (m_idle_run == 0) e_st = 2'd2;
    else e_st = 2'd3;
`ifdef NVDLA_CACC_SLCG_STATS_EN
    e_cnt = m_cnt;
`else
    e_cnt = 32'd0;
`endif
    cmp("en_src_0", 32'(en_src_0), 32'(e_en0));
    cmp("en_src_1", 32'(en_src_1), 32'(e_en1));
    cmp("wake_ack", 32'(wake_ack), 32'(e_ack));
    cmp("dla_sync", 32'(dla_sync), 32'(m_dhist[1]));
    cmp("glb_sync", 32'(glb_sync), 32'(m_ghist[1]));
    cmp("gate_state", 32'(gate_state), 32'(e_st));
    cmp("gated_cnt", gated_cycle_cnt, e_cnt);
    if (use_tbl) begin
      cmp("tbl_en_src_0", 32'(en_src_0), 32'(v.e_en0));
      cmp("tbl_en_src_1", 32'(en_src_1), 32'(v.e_en1));
      cmp("tbl_wake_ack", 32'(wake_ack), 32'(v.e_ack));
      cmp("tbl_dla_sync", 32'(dla_sync), 32'(v.e_dsync));
      cmp("tbl_glb_sync", 32'(glb_sync), 32'(v.e_gsync));
      cmp("tbl_gate_state", 32'(gate_state), 32'(v.e_st));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_tbl);
    for (int i = 0; i < v.len; i++) begin
      rstn = v.rstn; op_en = v.op; activity_req = v.act; dp_busy = v.busy;
      csb_req = v.csb; dla_ovr = v.dla; glb_ovr = v.glb; stats_clr = v.clr;
      @(negedge clk);
      checkOutput(v, use_tbl && (i == v.len - 1));
      @(posedge clk);
      modelStep();
      cyc++;
      #1;
    end
  endtask

  initial begin
    vec_t v;
    bit cur_dla, cur_glb, quiet;
    logic [31:0] exp_cnt;

    rstn = 0; op_en = 0; activity_req = 0; dp_busy = 0; csb_req = 0;
    dla_ovr = 0; glb_ovr = 0; stats_clr = 0;
    @(posedge clk);
    resetModel();
    #1;

    //              r op ac bu cs dl gl cl len  e0 e1 ea ed eg st
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  8,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  1, 1, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  1, 1, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  1, 1, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  5,  1, 1, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16,  1, 1, 1, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  4,  1, 1, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  9,  1, 1, 1, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  1,  1, 1, 1, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  1, 1, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 15,  1, 1, 1, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,  1,  0, 1, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  4,  0, 1, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  2,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  1,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  2,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,  3,  1, 1, 1, 1, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  3,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  3,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0,  1,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0,  3,  1, 1, 1, 0, 1, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 16,  1, 1, 1, 0, 1, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  1,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  2,  1, 1, 1, 0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  1,  1, 1, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  2,  1, 1, 0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0,  1,  1, 1, 1, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 17,  0, 0, 0, 0, 0, 2'd0));

    foreach (vecs[i]) applyStimulus(vecs[i], 1'b1);

    // Random traffic in alternating busy and quiet phases so gating happens.
    cur_dla = 0; cur_glb = 0; quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) quiet = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) cur_dla = ~cur_dla;
      if ($urandom_range(0, 49) == 0) cur_glb = ~cur_glb;
      v = mk(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 3) != 0),
             quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1),
             quiet ? 1'b0 : ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0),
             cur_dla, cur_glb,
             ($urandom_range(0, 99) == 0),
             1, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(v, 1'b0);
    end

    // Statistics: 100 idle cycles after reset, then a clear.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 2'd0), 1'b0);
`ifdef NVDLA_CACC_SLCG_STATS_EN
    exp_cnt = 32'd100;
`else
    exp_cnt = 32'd0;
`endif
    @(negedge clk);
    cmp("stats_after_100", gated_cycle_cnt, exp_cnt);
    @(posedge clk);
    modelStep();
    cyc++;
    #1;
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0), 1'b0);
    stats_clr = 0;
    @(negedge clk);
    cmp("stats_after_clr", gated_cycle_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
